// File: rtl/latch_capture_reader.sv
// Clocked reader for a transparent latch bank: synchronizes enable/Q, captures Q on each
// latch closing into a small FIFO, and flags Q changes while the latch is closed.
//
// state   | meaning
// --------+------------------------------------------------------------
// WAIT    | latch content unknown since reset; wait for the latch to open
// OPEN    | latch transparent; no checks
// CAPTURE | one cycle: push q_s into the FIFO and record it as held value
// CLOSED  | latch closed; any change of q_s against held value is a hold error
module latch_capture_reader #(
  parameter int WIDTH       = 8,
  parameter int DEPTH       = 4,
  parameter int SYNC_STAGES = 2,
  parameter int CNT_W       = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable,
  input  logic [WIDTH-1:0] Q,
  input  logic             clr_flags,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             overflow,
  output logic             hold_err,
  output logic [CNT_W-1:0] capture_cnt
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {
    S_WAIT    = 2'd0,
    S_OPEN    = 2'd1,
    S_CAPTURE = 2'd2,
    S_CLOSED  = 2'd3
  } state_t;

  state_t state_q, state_d;

  logic [SYNC_STAGES-1:0] en_sync_q;
  logic [WIDTH-1:0]       q_sync_q [SYNC_STAGES];
  logic                   en_s;
  logic [WIDTH-1:0]       q_s;

  logic [WIDTH-1:0] held_q;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] capture_cnt_q;
  logic             overflow_q, hold_err_q;

  logic push, hold_chk;
  logic empty, full, pop, push_ok, drop, hold_viol;

  // Both inputs are fully asynchronous to clk; only the last stage is used downstream.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      en_sync_q <= '0;
      for (int i = 0; i < SYNC_STAGES; i++) q_sync_q[i] <= '0;
    end else begin
      en_sync_q <= {en_sync_q[SYNC_STAGES-2:0], enable};
      q_sync_q[0] <= Q;
      for (int i = 1; i < SYNC_STAGES; i++) q_sync_q[i] <= q_sync_q[i-1];
    end
  end

  assign en_s = en_sync_q[SYNC_STAGES-1];
  assign q_s  = q_sync_q[SYNC_STAGES-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_WAIT;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_WAIT:    if (en_s)  state_d = S_OPEN;
      S_OPEN:    if (!en_s) state_d = S_CAPTURE;
      S_CAPTURE: state_d = S_CLOSED;
      S_CLOSED:  if (en_s)  state_d = S_OPEN;
      default:   state_d = S_WAIT;
    endcase
  end

  always_comb begin
    push     = 1'b0;
    hold_chk = 1'b0;
    unique case (state_q)
      S_CAPTURE: push = 1'b1;
      S_CLOSED:  hold_chk = !en_s;
      default:   ;
    endcase
  end

  assign empty     = (wr_ptr_q == rd_ptr_q);
  assign full      = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign pop       = !empty && out_ready;
  // A full FIFO still accepts a capture when the head leaves in the same cycle.
  assign push_ok   = push && (!full || pop);
  assign drop      = push && full && !pop;
  assign hold_viol = hold_chk && (q_s != held_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (push_ok) begin
        mem_q[wr_ptr_q[AW-1:0]] <= q_s;
        wr_ptr_q <= wr_ptr_q + (AW+1)'(1);
      end
      if (pop) rd_ptr_q <= rd_ptr_q + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      held_q        <= '0;
      capture_cnt_q <= '0;
      overflow_q    <= 1'b0;
      hold_err_q    <= 1'b0;
    end else begin
      if (push) begin
        held_q        <= q_s;
        capture_cnt_q <= capture_cnt_q + CNT_W'(1);
      end
      overflow_q <= drop      || (overflow_q && !clr_flags);
      hold_err_q <= hold_viol || (hold_err_q && !clr_flags);
    end
  end

  assign out_valid   = !empty;
  assign out_data    = empty ? '0 : mem_q[rd_ptr_q[AW-1:0]];
  assign overflow    = overflow_q;
  assign hold_err    = hold_err_q;
  assign capture_cnt = capture_cnt_q;

endmodule

// File: doc/latch_capture_reader.md
Name: latch_capture_reader

Overview:
- Clocked reader for a transparent D latch bank: it observes the latch's enable and Q, both asynchronous to clk.
- Detects each closing of the latch, i.e. enable falling, and captures the held Q value.
- Queues captured values in a small FIFO and delivers them downstream through a valid/ready handshake.
- While the latch is closed, flags any change on Q (hold violation). Sits between latch-based storage and synchronous consumer logic.

Parameters:
- WIDTH, 8, width of latch Q and of captured data.
- DEPTH, 4, FIFO entries; power of two, ≥2.
- SYNC_STAGES, 2, synchronizer flops on enable and Q; ≥2.
- CNT_W, 8, width of the capture counter.

Ports:
- clk  input  1  clock.
- rst_n  input  1  asynchronous active-low reset.
- enable  input  1  latch enable (async); high = latch transparent.
- Q  input  WIDTH  latch output (async).
- clr_flags  input  1  synchronous clear of overflow and hold_err.
- out_valid  output  1  out_data holds a captured value.
- out_ready  input  1  consumer accepts out_data.
- out_data  output  WIDTH  oldest captured value (FIFO head).
- overflow  output  1  sticky: a capture was dropped because the FIFO was full.
- hold_err  output  1  sticky: Q changed while the latch was closed.
- capture_cnt  output  CNT_W  number of closings detected; wraps modulo 2^CNT_W.

Behaviour:
- Reset (rst_n low, asynchronous):
  - All synchronizer flops 0.
  - FIFO empty; out_valid=0; out_data=0.
  - overflow=0; hold_err=0; capture_cnt=0.
  - FSM in WAIT.
- Synchronization: enable and Q each pass through SYNC_STAGES flops, giving en_s and q_s. Only en_s and q_s feed logic.
- FSM states:
  - WAIT: latch content unknown. en_s=1 -> OPEN; otherwise stay. Never captures, never checks hold.
  - OPEN: latch transparent, no checks. en_s=0 -> CAPTURE.
  - CAPTURE (exactly one cycle):
    - Pushes q_s into the FIFO and stores q_s in held_reg.
    - capture_cnt += 1, counting dropped captures as well.
    - -> CLOSED.
  - CLOSED:
    - Each cycle, q_s != held_reg sets hold_err.
    - en_s=1 -> OPEN, with no hold check in that cycle.
- Latency:
  - enable falling just before clk edge k gives en_s=0 at edge k+SYNC_STAGES-1.
  - CAPTURE occurs in the following cycle.
  - With an empty FIFO, out_valid rises one cycle after CAPTURE; with SYNC_STAGES=2 that is edge k+3.
- An enable high pulse shorter than one clk period may be missed. No capture is required for it; this is not an error.
- FIFO and handshake:
  - out_valid = not empty. out_data = head entry, held stable while out_valid=1 and out_ready=0.
  - Pop on out_valid & out_ready.
  - Push in CAPTURE.
  - Full, with push and no pop: the value is dropped and overflow is set; FIFO contents are unchanged.
  - Full, with push and pop in the same cycle: both happen; no overflow.
  - Empty with push: no bypass; out_valid rises next cycle.
  - Read and write pointers wrap modulo DEPTH. Full/empty is tracked with an extra pointer bit or an occupancy counter.
- Sticky flags:
  - clr_flags=1 clears overflow and hold_err at the next edge.
  - If a set condition and clr_flags occur in the same cycle, set wins.
- capture_cnt wraps from 2^CNT_W-1 to 0.
- Reset mid-operation: all state returns to reset values immediately, including queued data. After release the FSM re-enters WAIT, so a latch already closed is not captured until it reopens and closes again.

Test Plan:
- Reset, then enable=1, Q=8'h00, then Q=8'h5A, then enable=0; hold out_ready=0.
  -> Exactly one capture: out_valid=1, out_data=8'h5A, capture_cnt=1, hold_err=0. Raise out_ready -> out_valid=0 after one cycle.
- Five open/close cycles with Q=8'h01..8'h05 and out_ready=0 (DEPTH=4).
  -> Entries 01..04 queued; overflow=1; capture_cnt=5. Draining yields 01,02,03,04, then out_valid=0.
- FIFO full, out_ready=1 in the same cycle as a CAPTURE of 8'hAA.
  -> Head pops, AA enters the tail, overflow stays 0, and the drain order is preserved.
- Capture 8'h3C, then with enable=0 change Q to 8'h3D for 3 cycles.
  -> hold_err=1 and stays set. Pulse clr_flags -> hold_err=0, as long as Q is back at 8'h3C.
- Hold enable=0 from reset with Q=8'hFF.
  -> No capture, out_valid=0, hold_err=0. Open, close with Q=8'h11 -> one capture of 8'h11.
- Queue 2 entries, assert rst_n=0 asynchronously between clock edges.
  -> out_valid=0, capture_cnt=0, overflow=0 immediately. After release, the FSM is in WAIT and nothing is captured until an enable rise then fall.
